// File: rtl/vector_irq_ctrl.sv
// ---------------------------------------------------------------------------
// vector_irq_ctrl
//   Vectored interrupt controller sitting between N peripheral request lines
//   and the CPU interrupt-vector bus. It raises virq_o while any channel
//   requests service. When the CPU strobes istb_i, it latches the vector of
//   the highest-priority requester (channel 0 highest) and raises iack_o. It
//   also pulses that channel's ack_o for one cycle so the device drops its
//   request. After the strobe ends, virq_o is held low for HOLDOFF cycles
//   before new requests are reported.
//
// Ports
//   wb_clk_i  in   1     system clock, rising edge
//   wb_rst_n  in   1     asynchronous active-low reset
//   init_i    in   1     synchronous clear (bus INIT), overrides all inputs
//   irq_i     in   N     level requests, one per channel
//   vec_i     in   16*N  channel vectors, channel n at [16n+15:16n]
//   ack_o     out  N     one-cycle one-hot grant pulse to the served channel
//   virq_o    out  1     interrupt request to the CPU
//   istb_i    in   1     vector strobe from the CPU
//   ivec_o    out  16    vector presented to the CPU (0 when idle)
//   iack_o    out  1     vector acknowledge to the CPU
// ---------------------------------------------------------------------------
module vector_irq_ctrl #(
    parameter int          N           = 4,
    parameter logic [15:0] DEFAULT_VEC = 16'o0,
    parameter int          HOLDOFF     = 2
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic            init_i,
    input  logic [N-1:0]    irq_i,
    input  logic [16*N-1:0] vec_i,
    output logic [N-1:0]    ack_o,
    output logic            virq_o,
    input  logic            istb_i,
    output logic [15:0]     ivec_o,
    output logic            iack_o
);

    localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_HOLD
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_nxt;
    logic         r_virq;
    logic         w_virq_nxt;
    logic         r_iack;
    logic         w_iack_nxt;
    logic [15:0]  r_ivec;
    logic [15:0]  w_ivec_nxt;
    logic [N-1:0] r_ack;
    logic [N-1:0] w_ack_nxt;

    logic         w_any;
    logic [15:0]  w_sel_vec;
    logic [N-1:0] w_sel_onehot;

    // Priority encode: scanning from the top index down lets the lowest
    // requesting index win, producing both its vector and its one-hot grant.
    always_comb begin
        w_sel_vec    = DEFAULT_VEC;
        w_sel_onehot = '0;
        for (int n = N - 1; n >= 0; n--) begin
            if (irq_i[n]) begin
                w_sel_vec       = vec_i[16*n +: 16];
                w_sel_onehot    = '0;
                w_sel_onehot[n] = 1'b1;
            end
        end
    end

    assign w_any = |irq_i;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_virq_nxt  = 1'b0;
        w_iack_nxt  = r_iack;
        w_ivec_nxt  = r_ivec;
        w_ack_nxt   = '0;

        if (init_i) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_iack_nxt  = 1'b0;
            w_ivec_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_virq_nxt = w_any;
                    if (istb_i) begin
                        // A request withdrawn just as the strobe arrives still
                        // gets an acknowledge (with the default vector) so the
                        // CPU never stalls waiting for iack.
                        w_virq_nxt  = 1'b0;
                        w_ivec_nxt  = w_sel_vec;
                        w_iack_nxt  = 1'b1;
                        w_ack_nxt   = w_sel_onehot;
                        w_state_nxt = ST_ACK;
                    end
                end
                ST_ACK: begin
                    // Vector stays frozen while the CPU holds the strobe.
                    if (!istb_i) begin
                        w_iack_nxt  = 1'b0;
                        w_ivec_nxt  = '0;
                        w_cnt_nxt   = HOLD_INIT;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_iack_nxt  = 1'b0;
                    w_ivec_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_virq  <= 1'b0;
            r_iack  <= 1'b0;
            r_ivec  <= '0;
            r_ack   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_virq  <= w_virq_nxt;
            r_iack  <= w_iack_nxt;
            r_ivec  <= w_ivec_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    assign virq_o = r_virq;
    assign iack_o = r_iack;
    assign ivec_o = r_ivec;
    assign ack_o  = r_ack;

endmodule
